// File: rtl/sdram_arbit_mp.sv
// sdram_arbit_mp: multi-port SDRAM command arbiter.
//
// Sits between the init, auto-refresh, write and read engines and NPORT user ports, and owns the
// SDRAM pins. After init completes it arbitrates round-robin across the user ports, with refresh
// always taking precedence. Each grant is latched for the whole burst. Address and write data of
// the granted port are steered to the shared engines. Every SDRAM pin is registered, so the pins
// lag the engine values by exactly one sys_clk.
//
// Ports:
//   sys_clk, sys_rst            clock, asynchronous active-high reset
//   init_*                      init engine command/bank/address and completion
//   aref_*                      refresh request, completion, command/bank/address
//   wr_*                        write engine command/bank/address, end of burst, data-drive enable
//   rd_*                        read engine command/bank/address, end of burst
//   port_req/port_wr            per-port request level and direction (1 = write)
//   port_addr/port_wr_data      per-port start address and write data, flattened by port index
//   aref_en/wr_en/rd_en         engine enables
//   eng_addr                    start address of the granted port
//   port_gnt/port_done          one-hot grant, one-cycle end-of-burst pulse
//   sdram_*                     registered SDRAM pins, sdram_dq tristate

module sdram_arbit_mp #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned RW    = 13,
  parameter int unsigned BW    = 2,
  parameter int unsigned PAW   = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [3:0]         init_cmd,
  input  logic [BW-1:0]      init_ba,
  input  logic [RW-1:0]      init_addr,
  input  logic               init_end,
  input  logic               aref_req,
  input  logic               aref_end,
  input  logic [3:0]         aref_cmd,
  input  logic [BW-1:0]      aref_ba,
  input  logic [RW-1:0]      aref_addr,
  input  logic [3:0]         wr_cmd,
  input  logic [BW-1:0]      wr_ba,
  input  logic [RW-1:0]      wr_addr,
  input  logic               wr_end,
  input  logic               wr_sdram_en,
  input  logic [3:0]         rd_cmd,
  input  logic [BW-1:0]      rd_ba,
  input  logic [RW-1:0]      rd_addr,
  input  logic               rd_end,
  input  logic [NPORT-1:0]   port_req,
  input  logic [NPORT-1:0]   port_wr,
  input  logic [NPORT*PAW-1:0] port_addr,
  input  logic [NPORT*DW-1:0]  port_wr_data,
  output logic               aref_en,
  output logic               wr_en,
  output logic               rd_en,
  output logic [PAW-1:0]     eng_addr,
  output logic [NPORT-1:0]   port_gnt,
  output logic [NPORT-1:0]   port_done,
  output logic               sdram_cke,
  output logic               sdram_cs_n,
  output logic               sdram_ras_n,
  output logic               sdram_cas_n,
  output logic               sdram_we_n,
  output logic [BW-1:0]      sdram_ba,
  output logic [RW-1:0]      sdram_addr,
  inout  wire  [DW-1:0]      sdram_dq
);

  localparam int unsigned IW     = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [3:0]  CmdNop = 4'b0111;

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StArbit = 5'b00010,
    StAref  = 5'b00100,
    StWrite = 5'b01000,
    StRead  = 5'b10000
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
  logic              aref_en_q, aref_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [NPORT-1:0]  port_gnt_q, port_gnt_d;
  logic [NPORT-1:0]  port_done_q, port_done_d;
  logic [PAW-1:0]    eng_addr_q, eng_addr_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BW-1:0]     ba_q, ba_d;
  logic [RW-1:0]     addr_q, addr_d;
  logic              cke_q;
  logic              dq_oe_q, dq_oe_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;

  // Round-robin pick: first requester at or after rr_ptr_q, wrapping modulo NPORT.
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic [IW:0]       scan;
  logic [IW-1:0]     ptr_next;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NPORT)) begin
        scan = scan - (IW+1)'(NPORT);
      end
      if (!sel_found && port_req[scan[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[IW-1:0];
      end
    end
  end

  assign ptr_next = (gnt_idx_q == IW'(NPORT - 1)) ? '0 : gnt_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    aref_en_d   = aref_en_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = rd_en_q;
    port_gnt_d  = port_gnt_q;
    port_done_d = '0;
    eng_addr_d  = eng_addr_q;
    cmd_d       = CmdNop;
    ba_d        = '1;
    addr_d      = '1;
    dq_oe_d     = wr_sdram_en & (state_q == StWrite);
    wr_data_d   = port_wr_data[gnt_idx_q*DW +: DW];

    unique case (state_q)
      StIdle: begin
        cmd_d  = init_cmd;
        ba_d   = init_ba;
        addr_d = init_addr;
        if (init_end) begin
          state_d = StArbit;
        end
      end
      StArbit: begin
        if (aref_req) begin
          state_d   = StAref;
          aref_en_d = 1'b1;
        end else if (sel_found) begin
          gnt_idx_d           = sel_idx;
          port_gnt_d          = '0;
          port_gnt_d[sel_idx] = 1'b1;
          eng_addr_d          = port_addr[sel_idx*PAW +: PAW];
          if (port_wr[sel_idx]) begin
            state_d = StWrite;
            wr_en_d = 1'b1;
          end else begin
            state_d = StRead;
            rd_en_d = 1'b1;
          end
        end
      end
      StAref: begin
        cmd_d  = aref_cmd;
        ba_d   = aref_ba;
        addr_d = aref_addr;
        if (aref_end) begin
          state_d   = StArbit;
          aref_en_d = 1'b0;
        end
      end
      StWrite: begin
        cmd_d  = wr_cmd;
        ba_d   = wr_ba;
        addr_d = wr_addr;
        if (wr_end) begin
          state_d     = StArbit;
          wr_en_d     = 1'b0;
          port_done_d = port_gnt_q;
          port_gnt_d  = '0;
          rr_ptr_d    = ptr_next;
        end
      end
      StRead: begin
        cmd_d  = rd_cmd;
        ba_d   = rd_ba;
        addr_d = rd_addr;
        if (rd_end) begin
          state_d     = StArbit;
          rd_en_d     = 1'b0;
          port_done_d = port_gnt_q;
          port_gnt_d  = '0;
          rr_ptr_d    = ptr_next;
        end
      end
      default: begin
        // Illegal encoding: fall back to a clean restart.
        state_d    = StIdle;
        aref_en_d  = 1'b0;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        port_gnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      aref_en_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      port_gnt_q  <= '0;
      port_done_q <= '0;
      eng_addr_q  <= '0;
      cmd_q       <= CmdNop;
      ba_q        <= '1;
      addr_q      <= '1;
      cke_q       <= 1'b0;
      dq_oe_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      aref_en_q   <= aref_en_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      port_gnt_q  <= port_gnt_d;
      port_done_q <= port_done_d;
      eng_addr_q  <= eng_addr_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      cke_q       <= 1'b1;
      dq_oe_q     <= dq_oe_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign eng_addr  = eng_addr_q;
  assign port_gnt  = port_gnt_q;
  assign port_done = port_done_q;

  assign sdram_cke = cke_q;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_ba   = ba_q;
  assign sdram_addr = addr_q;
  assign sdram_dq   = dq_oe_q ? wr_data_q : {DW{1'bz}};

endmodule
